arm_fetch_unit: RTL and testbench
=================================

Name: arm_fetch_unit

Overview:
- Instruction fetch front-end for the ARM core.
- Produces the 32-bit instruction word that the controller/decoder consumes.
- Consumes the controller's PCSrc redirect (with target from the datapath ALU result).
- Drives a request/response instruction-memory port with variable latency, and buffers fetched words in a small FIFO so decode can stall without losing data.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch byte address; bits [1:0] always 0.
- imem_ready  in  1  memory accepts request this cycle when imem_req && imem_ready.
- imem_rvalid  in  1  response data valid; exactly one response per accepted request.
- imem_rdata  in  32  instruction word.
- PCSrc  in  1  redirect strobe from controller, one cycle.
- BranchTarget  in  32  redirect address; bits [1:0] ignored and treated as 0.
- Instr  out  32  head-of-FIFO instruction; 0 when empty.
- InstrPC  out  32  byte address of Instr.
- InstrValid  out  1  Instr is valid.
- InstrReady  in  1  decode consumes Instr when InstrValid && InstrReady.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; state=FETCH.
  - Outputs: imem_req=0, imem_addr=RESET_PC, Instr=0, InstrPC=0, InstrValid=0.
  - imem_req is gated low while reset is asserted.
- Outstanding requests: at most one. Space test is fifo_count + outstanding < FIFO_DEPTH.
- States:
  - FETCH: imem_req=1 iff the space test passes and PCSrc=0; imem_addr=fetch_pc.
    - On accept: fetch_pc += 4 (32-bit wrap: 32'hFFFF_FFFC -> 0); go to WAIT.
  - WAIT: imem_req=0.
    - On imem_rvalid: push {imem_rdata, req_pc} into FIFO; go to FETCH.
  - DISCARD: imem_req=0.
    - On imem_rvalid: drop data; go to FETCH.
- Latency:
  - Request asserted the first cycle after reset release.
  - Accepted word is visible on Instr/InstrValid the cycle after imem_rvalid (registered push).
  - Back-to-back throughput with zero-wait memory: one instruction per 2 cycles (single outstanding).
- Pop: when InstrValid && InstrReady, head advances on the edge. Push and pop in the same cycle leave the count unchanged.
- Redirect (PCSrc=1):
  - FIFO cleared on that edge, including any same-cycle push or pop.
  - fetch_pc <= {BranchTarget[31:2],2'b00}.
  - FETCH: no request issued that cycle; stay in FETCH.
  - WAIT without rvalid: go to DISCARD.
  - WAIT with rvalid the same cycle: data dropped; go to FETCH.
  - DISCARD: stay in DISCARD, or go to FETCH if rvalid is present; the target is updated either way.
  - InstrValid=0 the cycle after redirect.
- Full FIFO: no request issued; existing entries held until popped.
- imem_rvalid outside WAIT/DISCARD is a protocol error, ignored. Bench asserts it never occurs.
- Reset mid-transaction: all state cleared immediately. The memory is reset by the same signal, so no stale response is expected.

Decomposition:
- Package arm_fetch_pkg:
  - typedef enum logic [1:0] {FETCH, WAIT, DISCARD} fetch_state_t
  - localparam WORD_BYTES=4
  - typedef struct packed {logic [31:0] instr; logic [31:0] pc;} fetch_entry_t
- Sub-module arm_fetch_fifo:
  - Parameterized DEPTH; stores fetch_entry_t.
  - Ports: push, pop, flush, count, head, empty, full.
  - Flush has priority over push and pop.
- FSM, PC and redirect logic stay in arm_fetch_unit.

Test Plan:
- Reset release, RESET_PC=0, memory always ready, 1-cycle latency, InstrReady=1 -> imem_addr sequence 0,4,8,…; Instr/InstrPC pairs match memory contents in order; one InstrValid every 2 cycles.
- InstrReady=0 held for 10 cycles -> exactly FIFO_DEPTH (2) entries fetched, then imem_req stays 0. Release -> entries drain in order (PC 0, then 4) and fetching resumes at 8.
- PCSrc with BranchTarget=32'h0000_0103 while in WAIT, response delayed 3 cycles -> delayed word discarded; next request address 32'h0000_0100; InstrValid=0 until the 0x100 word arrives.
- PCSrc in the same cycle as imem_rvalid and InstrReady, with a 1-entry FIFO -> FIFO empty next cycle; next request address equals the target; no stale Instr ever presented.
- RESET_PC=32'hFFFF_FFF8, two sequential fetches -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Assert reset low mid-WAIT, then release -> outputs at reset values while reset is low; first post-release request at RESET_PC.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// Shared types for the ARM instruction fetch front-end.
package arm_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } fetch_state_t;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/arm_fetch_fifo.sv
// Small instruction buffer holding {instr, pc} entries; flush wins over push/pop.
module arm_fetch_fifo
    import arm_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/arm_fetch_unit.sv
// Fetch front-end: single-outstanding imem requests, redirect handling, buffered output.
module arm_fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;

    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          outstanding;
    logic          space;
    logic          accept;
    logic          unused_bt_lsb;

    assign unused_bt_lsb = ^BranchTarget[1:0];
    assign outstanding   = (state_q != FETCH);
    // A slot is reserved for the in-flight response so it can never overflow the buffer.
    assign space  = !fifo_full &&
                    (({{(32-CW){1'b0}}, fifo_count} + {31'd0, outstanding}) < FIFO_DEPTH);
    assign accept = imem_req && imem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            FETCH: begin
                if (accept) begin
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
                end
            end
            WAIT: begin
                if (imem_rvalid)  state_d = FETCH;
                else if (PCSrc)   state_d = DISCARD;
            end
            DISCARD: begin
                if (imem_rvalid)  state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (PCSrc) fetch_pc_d = {BranchTarget[31:2], 2'b00};
    end

    always_comb begin
        imem_req         = reset && (state_q == FETCH) && space && !PCSrc;
        imem_addr        = fetch_pc_q;
        fifo_push        = (state_q == WAIT) && imem_rvalid;
        push_entry.instr = imem_rdata;
        push_entry.pc    = req_pc_q;
        InstrValid       = !fifo_empty;
        fifo_pop         = !fifo_empty && InstrReady;
        Instr            = fifo_empty ? '0 : fifo_head.instr;
        InstrPC          = fifo_empty ? '0 : fifo_head.pc;
    end

    arm_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (PCSrc),
        .count     (fifo_count),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Directed bench for arm_fetch_unit with a variable-latency instruction memory model.
module tb_arm_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        PCSrc = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady = 1'b1;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic        rv2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        valid2;
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] zero32 = '0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    arm_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Instr(Instr), .InstrPC(InstrPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady)
    );

    arm_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .reset(rst2_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(one), .imem_rvalid(rv2), .imem_rdata(rdata2),
        .PCSrc(zero), .BranchTarget(zero32), .Instr(instr2), .InstrPC(pc2),
        .InstrValid(valid2), .InstrReady(one)
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hE1A0_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model state
    bit          pend = 0;
    int unsigned cnt = 0;
    int unsigned mem_lat = 1;
    logic [31:0] paddr = '0;
    logic        s_acc, s_acc2;
    logic [31:0] s_addr, s_addr2;

    // Called at the negedge sample point; finishes the cycle and updates memory outputs.
    task automatic end_cycle();
        if (imem_req && imem_ready && rst_n) begin
            chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            chk("single_outstanding", {31'd0, pend}, 32'd0);
        end
        s_acc   = imem_req && imem_ready && rst_n;
        s_addr  = imem_addr;
        s_acc2  = req2 && rst2_n;
        s_addr2 = addr2;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (s_acc) begin
                pend  = 1;
                cnt   = mem_lat;
                paddr = s_addr;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mw(paddr);
                    pend        = 0;
                end
            end
        end
        rv2    = s_acc2;
        rdata2 = s_acc2 ? mw(s_addr2) : '0;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ps;
        logic [31:0] bt;
        int unsigned lat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    function automatic vec_t mk(logic r, logic rdy, logic ps, logic [31:0] bt, int unsigned lat,
                                logic eq, logic [31:0] ea, logic ev, logic [31:0] ep);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.ps = ps; t.bt = bt; t.lat = lat;
        t.e_req = eq; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep;
        return t;
    endfunction

    initial begin
        // Streaming, zero-wait memory, decode always ready
        vecs.push_back(mk(0,1,0,0,1, 0,32'h0,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h0,0,0));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h4,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h4,1,32'h0));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h8,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h8,1,32'h4));
        vecs.push_back(mk(1,1,0,0,1, 0,32'hC,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'hC,1,32'h8));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h10,0,0));
        // Decode stalled 10 cycles: buffer fills, requests stop, then drains in order
        vecs.push_back(mk(0,1,0,0,1, 0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 1,32'h0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0,32'h4,0,0));
        vecs.push_back(mk(1,0,0,0,1, 1,32'h4,1,32'h0));
        vecs.push_back(mk(1,0,0,0,1, 0,32'h8,1,32'h0));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(1,0,0,0,1, 0,32'h8,1,32'h0));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h8,1,32'h0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h8,1,32'h4));
        vecs.push_back(mk(1,1,0,0,1, 0,32'hC,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'hC,1,32'h8));
        // Redirect in WAIT with a 3-cycle response: stale word discarded
        vecs.push_back(mk(0,1,0,0,3, 0,32'h0,0,0));
        vecs.push_back(mk(1,1,0,0,3, 1,32'h0,0,0));
        vecs.push_back(mk(1,1,1,32'h103,3, 0,32'h4,0,0));
        vecs.push_back(mk(1,1,0,0,3, 0,32'h100,0,0));
        vecs.push_back(mk(1,1,0,0,3, 0,32'h100,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h100,0,0));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h104,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h104,1,32'h100));
        // Redirect together with rvalid and pop on a one-entry buffer, then redirect in FETCH
        vecs.push_back(mk(0,1,0,0,1, 0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 1,32'h0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0,32'h4,0,0));
        vecs.push_back(mk(1,0,0,0,1, 1,32'h4,1,32'h0));
        vecs.push_back(mk(1,1,1,32'h200,1, 0,32'h8,1,32'h0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h200,0,0));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h204,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h204,1,32'h200));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h208,0,0));
        vecs.push_back(mk(1,0,1,32'h300,1, 0,32'h208,1,32'h204));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h300,0,0));
        // Reset asserted mid-WAIT
        vecs.push_back(mk(0,1,0,0,3, 0,32'h0,0,0));
        vecs.push_back(mk(1,1,0,0,3, 1,32'h0,0,0));
        vecs.push_back(mk(0,1,0,0,3, 0,32'h0,0,0));
        vecs.push_back(mk(0,1,0,0,3, 0,32'h0,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h0,0,0));
        vecs.push_back(mk(1,1,0,0,1, 0,32'h4,0,0));
        vecs.push_back(mk(1,1,0,0,1, 1,32'h4,1,32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst_n        = v.rst;
            InstrReady   = v.rdy;
            PCSrc        = v.ps;
            BranchTarget = v.bt;
            mem_lat      = v.lat;
            @(negedge clk);
            chk($sformatf("v%0d imem_req", i),   {31'd0, imem_req},   {31'd0, v.e_req});
            chk($sformatf("v%0d imem_addr", i),  imem_addr,           v.e_addr);
            chk($sformatf("v%0d InstrValid", i), {31'd0, InstrValid}, {31'd0, v.e_valid});
            chk($sformatf("v%0d InstrPC", i),    InstrPC,             v.e_valid ? v.e_pc : 32'h0);
            chk($sformatf("v%0d Instr", i),      Instr,               v.e_valid ? mw(v.e_pc) : 32'h0);
            end_cycle();
        end

        // Address wrap from RESET_PC = FFFF_FFF8 on the second instance
        rst_n = 1'b0;
        PCSrc = 1'b0;
        @(negedge clk);
        chk("wrap rst imem_req",  {31'd0, req2},   32'd0);
        chk("wrap rst imem_addr", addr2,           32'hFFFF_FFF8);
        chk("wrap rst InstrValid",{31'd0, valid2}, 32'd0);
        end_cycle();
        rst2_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            case (c)
                0: begin
                    chk("wrap c0 req",  {31'd0, req2}, 32'd1);
                    chk("wrap c0 addr", addr2,         32'hFFFF_FFF8);
                end
                2: begin
                    chk("wrap c2 req",   {31'd0, req2}, 32'd1);
                    chk("wrap c2 addr",  addr2,         32'hFFFF_FFFC);
                    chk("wrap c2 pc",    pc2,           32'hFFFF_FFF8);
                    chk("wrap c2 instr", instr2,        mw(32'hFFFF_FFF8));
                end
                4: begin
                    chk("wrap c4 req",  {31'd0, req2}, 32'd1);
                    chk("wrap c4 addr", addr2,         32'h0000_0000);
                    chk("wrap c4 pc",   pc2,           32'hFFFF_FFFC);
                end
                default: chk($sformatf("wrap c%0d req", c), {31'd0, req2}, 32'd0);
            endcase
            end_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
